pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline-stage register for the MIPS core. It is the successor of the fixed 32+32-bit stall/flush stage register.
- Carries an arbitrary-width payload (e.g. {PC_4, instr}) between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so back-pressure never forms a combinational path through the stage.
- Adds a valid bit, an occupancy indication, and a flush that takes priority over stall.

Parameters:
- DATA_W, 64, payload width in bits (minimum 1).
- BUBBLE_VAL, {DATA_W{1'b0}}, value loaded into both data registers on reset and flush (0 = MIPS NOP).
- CLEAR_ON_FLUSH, 1, 1 = data registers load BUBBLE_VAL on flush; 0 = only valid bits clear and data holds.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept; registered (= ~skid_valid)
- in_data  input  DATA_W  upstream payload
- flush  input  1  discard all held and incoming payloads this cycle
- out_valid  output  1  main register holds a payload (registered)
- out_ready  input  1  downstream accepts; out_ready=0 is a stall
- out_data  output  DATA_W  main register contents (registered)
- occ  output  2  entries held: 0, 1 or 2 (registered)

Behaviour:
- Storage: main register (main_v, main_d) drives the outputs; skid register (skid_v, skid_d) is internal.
- Handshake definitions:
  - acc = in_valid & in_ready
  - drn = out_valid & out_ready
  - A transfer occurs only when valid and ready are both high at a clock edge.
- Reset (rst=1 at an edge, highest priority): main_v=0, skid_v=0, main_d=skid_d=BUBBLE_VAL. After reset out_valid=0, in_ready=1, occ=0, out_data=BUBBLE_VAL.
- Flush (rst=0, flush=1, second priority):
  - main_v=0 and skid_v=0 at the edge. Any acc in the same cycle is dropped.
  - Data registers load BUBBLE_VAL if CLEAR_ON_FLUSH=1, otherwise they hold.
  - Flush overrides stall: out_ready=0 does not preserve contents.
- States, where occ = main_v + skid_v:
  - EMPTY (occ=0):
    - acc -> ONE; main_d<=in_data.
    - No acc -> stay EMPTY.
  - ONE (occ=1):
    - acc & drn -> ONE; main_d<=in_data.
    - acc & ~drn -> FULL; skid_d<=in_data, main holds.
    - ~acc & drn -> EMPTY.
    - ~acc & ~drn -> hold.
  - FULL (occ=2): in_ready=0, so acc is impossible.
    - drn -> ONE; main_d<=skid_d, skid_v<=0.
    - ~drn -> hold both entries.
- Latency: 1 cycle from acc to out_valid when EMPTY, or when ONE with a simultaneous drain. Throughput is 1 payload/cycle while out_ready=1.
- Ordering: strictly FIFO. No payload is duplicated or lost, except on flush or reset.
- Stalled outputs: while out_valid=1 & out_ready=0, out_data is stable.
- Other properties:
  - in_valid while in_ready=0 is ignored; it is not an error.
  - No combinational path from out_ready or in_valid to in_ready or out_valid.
  - in_data is sampled only on acc.
  - Reset mid-transfer discards everything, including a FULL state.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_data=64'h1234 -> out_valid=0, occ=0, in_ready=1, out_data=0 during and after reset.
- Streaming: out_ready=1; send 0x10,0x11,0x12,0x13 on consecutive cycles -> out_data shows each value exactly 1 cycle after acceptance; occ stays 1; in_ready stays 1.
- Stall/skid: send A=0x20, then B=0x21 with out_ready=0; then release out_ready after 3 cycles.
  - After A: occ=1.
  - After B: occ=2, in_ready=0, out_data=0x20 held; 0x22 offered while stalled is not accepted.
  - After release: outputs 0x20 then 0x21 in order.
- Flush during stall: state FULL (0x30,0x31), assert flush=1 with in_valid=1, in_data=0x32 -> next cycle occ=0, out_valid=0, out_data=0 (CLEAR_ON_FLUSH=1), 0x32 never appears at out_data.
- Flush with CLEAR_ON_FLUSH=0, DATA_W=8: hold 0x5A, flush -> out_valid=0, out_data still 0x5A; next accepted 0xA5 appears normally.
- Random: random in_valid, out_ready, flush over ~10k cycles, checked against a scoreboard FIFO -> no loss, duplication or reorder between flushes; occ always equals the scoreboard depth (0..2).

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic valid/ready pipeline register with a 2-entry skid buffer and flush.
module pipe_skid_stage #(
    parameter int                DATA_W         = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL     = '0,
    parameter bit                CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);
    logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d, skid_d_q, skid_d_d;
    logic              acc;
    assign acc = in_valid & ~skid_v_q;
    always_comb begin
        main_v_d = skid_v_q | acc | (main_v_q & ~out_ready);
        skid_v_d = skid_v_q ? ~out_ready : (acc & main_v_q & ~out_ready);
        main_d_d = (skid_v_q & out_ready) ? skid_d_q :
                   (acc & (~main_v_q | out_ready)) ? in_data : main_d_q;
        skid_d_d = (acc & main_v_q & ~out_ready) ? in_data : skid_d_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_d_q <= BUBBLE_VAL;
            skid_d_q <= BUBBLE_VAL;
        end else if (flush) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_d_q <= CLEAR_ON_FLUSH ? BUBBLE_VAL : main_d_q;
            skid_d_q <= CLEAR_ON_FLUSH ? BUBBLE_VAL : skid_d_q;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_d_q <= main_d_d;
            skid_d_q <= skid_d_d;
        end
    end
    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign occ       = {main_v_q & skid_v_q, main_v_q ^ skid_v_q};
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random checks of pipe_skid_stage against a queue-based model.
module tb_pipe_skid_stage;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [1:0]  occ;
    logic        in_valid8 = 1'b0, flush8 = 1'b0, out_ready8 = 1'b0;
    logic [7:0]  in_data8 = '0;
    logic        in_ready8, out_valid8;
    logic [7:0]  out_data8;
    logic [1:0]  occ8;
    int          tests = 0, fails = 0;
    logic [63:0] q[$];
    logic [63:0] exp_data = '0;

    pipe_skid_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occ(occ)
    );

    pipe_skid_stage #(.DATA_W(8), .BUBBLE_VAL(8'h00), .CLEAR_ON_FLUSH(1'b0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .occ(occ8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The model is a plain FIFO of at most two payloads; the visible word is its head,
    // or the last head after draining, or zero after reset/flush.
    task automatic cyc(input logic r, input logic iv, input logic [63:0] id, input logic ordy, input logic fl);
        bit a, d;
        rst = r; in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        @(posedge clk);
        if (r || fl) begin
            q.delete();
            exp_data = '0;
        end else begin
            a = iv && q.size() < 2;
            d = ordy && q.size() > 0;
            if (d) void'(q.pop_front());
            if (a) q.push_back(id);
            if (q.size() > 0) exp_data = q[0];
        end
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("occ", 64'(occ), 64'(q.size()));
        chk("out_data", out_data, exp_data);
    endtask

    initial begin
        cyc(1, 1, 64'h1234, 1, 0);
        chk("rst_hold_valid", 64'(out_valid), 64'h0);
        cyc(1, 1, 64'h1234, 1, 0);
        cyc(0, 0, 64'h0, 1, 0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_occ", 64'(occ), 64'h0);
        chk("rst8_valid", 64'(out_valid8), 64'h0);

        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 64'h10 + 64'(i), 1, 0);
            chk("stream_data", out_data, 64'h10 + 64'(i));
            chk("stream_occ", 64'(occ), 64'h1);
            chk("stream_ready", 64'(in_ready), 64'h1);
        end
        cyc(0, 0, 64'h0, 1, 0);

        cyc(0, 1, 64'h20, 0, 0);
        chk("skid_a_occ", 64'(occ), 64'h1);
        cyc(0, 1, 64'h21, 0, 0);
        chk("skid_b_occ", 64'(occ), 64'h2);
        chk("skid_b_ready", 64'(in_ready), 64'h0);
        chk("skid_b_data", out_data, 64'h20);
        cyc(0, 1, 64'h22, 0, 0);
        chk("skid_hold_data", out_data, 64'h20);
        chk("skid_hold_occ", 64'(occ), 64'h2);
        cyc(0, 0, 64'h0, 1, 0);
        chk("skid_rel_data", out_data, 64'h21);
        chk("skid_rel_occ", 64'(occ), 64'h1);
        cyc(0, 0, 64'h0, 1, 0);
        chk("skid_empty", 64'(out_valid), 64'h0);

        cyc(0, 1, 64'h30, 0, 0);
        cyc(0, 1, 64'h31, 0, 0);
        chk("fl_full", 64'(occ), 64'h2);
        cyc(0, 1, 64'h32, 0, 1);
        chk("fl_occ", 64'(occ), 64'h0);
        chk("fl_valid", 64'(out_valid), 64'h0);
        chk("fl_data", out_data, 64'h0);
        cyc(0, 0, 64'h0, 1, 0);
        chk("fl_no32", 64'(out_valid), 64'h0);

        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_valid8 = 1'b1; in_data8 = 8'h5A; out_ready8 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("nc_load_valid", 64'(out_valid8), 64'h1);
        chk("nc_load_data", 64'(out_data8), 64'h5A);
        in_valid8 = 1'b0; flush8 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("nc_flush_valid", 64'(out_valid8), 64'h0);
        chk("nc_flush_data", 64'(out_data8), 64'h5A);
        chk("nc_flush_occ", 64'(occ8), 64'h0);
        flush8 = 1'b0; in_valid8 = 1'b1; in_data8 = 8'hA5; out_ready8 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("nc_next_valid", 64'(out_valid8), 64'h1);
        chk("nc_next_data", 64'(out_data8), 64'hA5);
        in_valid8 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("nc_drained", 64'(out_valid8), 64'h0);

        for (int i = 0; i < 10000; i++)
            cyc($urandom_range(499) == 0, $urandom_range(1), {$urandom, $urandom},
                $urandom_range(9) < 6, $urandom_range(19) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
